// File: rtl/gba_lcd_pkg.sv
// Shared constants for the LCD timing block: DISPSTAT bit layout,
// default display geometry and the I/O register offsets it serves.
package gba_lcd_pkg;

    // DISPSTAT bit positions
    localparam int DS_VBLANK  = 0;
    localparam int DS_HBLANK  = 1;
    localparam int DS_VCMATCH = 2;
    localparam int DS_EN_VB   = 3;
    localparam int DS_EN_HB   = 4;
    localparam int DS_EN_VC   = 5;
    localparam int DS_LYC_LSB = 8;

    // Default geometry (50 MHz clk_mem, 12 cycles per dot)
    localparam int DEF_CLK_PER_DOT = 12;
    localparam int DEF_H_VISIBLE   = 240;
    localparam int DEF_H_TOTAL     = 308;
    localparam int DEF_V_VISIBLE   = 160;
    localparam int DEF_V_TOTAL     = 228;

    // Offsets inside the I/O register window
    localparam logic [11:0] IO_DISPSTAT_OFFS = 12'h004;
    localparam logic [11:0] IO_VCOUNT_OFFS   = 12'h006;

endpackage

// File: rtl/lcd_dot_divider.sv
// Divides clk_mem down to the LCD dot rate; dot_tick marks the last
// clk_mem cycle of each dot.
module lcd_dot_divider #(
    parameter int CLK_PER_DOT = 12,
    parameter int DIV_W       = 4
) (
    input  logic             clk_mem,
    input  logic             rst_n,
    output logic [DIV_W-1:0] div,
    output logic             dot_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_DOT - 1);

    assign dot_tick = (div == DIV_LAST);

    // free-running 0..CLK_PER_DOT-1 counter
    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (dot_tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

endmodule

// File: rtl/gba_lcd_timing.sv
// GBA-style LCD timing generator: dot/line counters, VCOUNT, DISPSTAT,
// single-cycle LCD interrupt requests and renderer pixel coordinates.
module gba_lcd_timing
    import gba_lcd_pkg::*;
#(
    parameter int CLK_PER_DOT = DEF_CLK_PER_DOT,
    parameter int H_VISIBLE   = DEF_H_VISIBLE,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int V_VISIBLE   = DEF_V_VISIBLE,
    parameter int V_TOTAL     = DEF_V_TOTAL
) (
    input  logic        clk_mem,
    input  logic        rst_n,
    input  logic [15:0] dispcnt,
    input  logic        dispstat_wr,
    input  logic [15:0] dispstat_wdata,
    input  logic [1:0]  dispstat_be,
    output logic [15:0] dispstat,
    output logic [7:0]  vcount,
    output logic        irq_vblank,
    output logic        irq_hblank,
    output logic        irq_vcount,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        pix_valid,
    output logic        pix_strobe
);

    localparam int DIV_W = (CLK_PER_DOT > 1) ? $clog2(CLK_PER_DOT) : 1;

    logic [DIV_W-1:0] div;
    logic             dot_tick;
    logic [8:0]       hcount;
    logic [7:0]       lyc;
    logic             en_vb, en_hb, en_vc;
    logic             vc_match;
    logic             line_end;
    logic             lyc_wr;
    logic [7:0]       vcount_nxt;
    logic [7:0]       lyc_nxt;
    logic             hblank, vblank, visible;
    logic             unused_inputs;

    lcd_dot_divider #(
        .CLK_PER_DOT (CLK_PER_DOT),
        .DIV_W       (DIV_W)
    ) u_div (
        .clk_mem  (clk_mem),
        .rst_n    (rst_n),
        .div      (div),
        .dot_tick (dot_tick)
    );

    assign line_end   = dot_tick && (hcount == 9'(H_TOTAL - 1));
    assign lyc_wr     = dispstat_wr && dispstat_be[1];
    assign lyc_nxt    = lyc_wr ? dispstat_wdata[15:8] : lyc;
    assign vcount_nxt = !line_end                      ? vcount :
                        (vcount == 8'(V_TOTAL - 1))    ? 8'd0   : vcount + 8'd1;

    // dot and line counters
    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (dot_tick) begin
            hcount <= (hcount == 9'(H_TOTAL - 1)) ? 9'd0 : hcount + 9'd1;
            vcount <= vcount_nxt;
        end
    end

    // DISPSTAT writable fields
    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            en_vb <= 1'b0;
            en_hb <= 1'b0;
            en_vc <= 1'b0;
            lyc   <= '0;
        end else if (dispstat_wr) begin
            if (dispstat_be[0]) begin
                en_vb <= dispstat_wdata[DS_EN_VB];
                en_hb <= dispstat_wdata[DS_EN_HB];
                en_vc <= dispstat_wdata[DS_EN_VC];
            end
            if (dispstat_be[1])
                lyc <= dispstat_wdata[15:8];
        end
    end

    // vc_match is re-evaluated only when the line or lyc changes, so it
    // reads 0 straight out of reset even though vcount == lyc == 0
    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n)
            vc_match <= 1'b0;
        else if (line_end || lyc_wr)
            vc_match <= (vcount_nxt == lyc_nxt);
    end

    // interrupt pulses, gated by the enables held before any same-cycle write
    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            irq_hblank <= 1'b0;
            irq_vblank <= 1'b0;
            irq_vcount <= 1'b0;
        end else begin
            irq_hblank <= dot_tick && (hcount == 9'(H_VISIBLE - 1)) && en_hb;
            irq_vblank <= line_end && (vcount == 8'(V_VISIBLE - 1)) && en_vb;
            irq_vcount <= line_end && (vcount_nxt == lyc) && en_vc;
        end
    end

    assign hblank  = (hcount >= 9'(H_VISIBLE));
    assign vblank  = (vcount >= 8'(V_VISIBLE)) && (vcount != 8'(V_TOTAL - 1));
    assign visible = !hblank && (vcount < 8'(V_VISIBLE));

    assign pix_valid  = !dispcnt[7] && visible;
    assign pix_strobe = pix_valid && (div == '0);
    assign pix_x      = visible ? hcount[7:0] : 8'd0;
    assign pix_y      = visible ? vcount      : 8'd0;

    // DISPSTAT readback image
    always_comb begin
        dispstat                       = '0;
        dispstat[DS_VBLANK]            = vblank;
        dispstat[DS_HBLANK]            = hblank;
        dispstat[DS_VCMATCH]           = vc_match;
        dispstat[DS_EN_VB]             = en_vb;
        dispstat[DS_EN_HB]             = en_hb;
        dispstat[DS_EN_VC]             = en_vc;
        dispstat[DS_LYC_LSB +: 8]      = lyc;
    end

    assign unused_inputs = ^{dispcnt[15:8], dispcnt[6:0],
                             dispstat_wdata[7:6], dispstat_wdata[2:0]};

endmodule

// File: tb/tb_gba_lcd_timing.sv
// Randomized bench for gba_lcd_timing against a time-based reference model
// (dot/line derived arithmetically from the cycle count since reset release).
module tb_gba_lcd_timing;

    localparam int C  = 3;
    localparam int HV = 8;
    localparam int HT = 12;
    localparam int VV = 6;
    localparam int VT = 10;
    localparam int FRAME = C * HT * VT;

    logic        clk_mem = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] dispcnt = 16'h0080;
    logic        dispstat_wr = 1'b0;
    logic [15:0] dispstat_wdata = '0;
    logic [1:0]  dispstat_be = '0;
    logic [15:0] dispstat;
    logic [7:0]  vcount;
    logic        irq_vblank, irq_hblank, irq_vcount;
    logic [7:0]  pix_x, pix_y;
    logic        pix_valid, pix_strobe;

    int errors = 0;
    int checks = 0;

    // model state
    int         t;
    bit         m_en_vb, m_en_hb, m_en_vc, m_vcm;
    logic [7:0] m_lyc;
    bit         p_wr;
    logic [15:0] p_wd;
    logic [1:0]  p_be;
    int         strobe_cnt;

    gba_lcd_timing #(
        .CLK_PER_DOT (C),
        .H_VISIBLE   (HV),
        .H_TOTAL     (HT),
        .V_VISIBLE   (VV),
        .V_TOTAL     (VT)
    ) dut (
        .clk_mem        (clk_mem),
        .rst_n          (rst_n),
        .dispcnt        (dispcnt),
        .dispstat_wr    (dispstat_wr),
        .dispstat_wdata (dispstat_wdata),
        .dispstat_be    (dispstat_be),
        .dispstat       (dispstat),
        .vcount         (vcount),
        .irq_vblank     (irq_vblank),
        .irq_hblank     (irq_hblank),
        .irq_vcount     (irq_vcount),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_valid      (pix_valid),
        .pix_strobe     (pix_strobe)
    );

    always #5 clk_mem = ~clk_mem;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_clear();
        t       = 0;
        m_en_vb = 0; m_en_hb = 0; m_en_vc = 0; m_vcm = 0;
        m_lyc   = 8'd0;
        p_wr    = 0; p_wd = '0; p_be = '0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk_mem); #1;
        dispstat_wr = 1'b0;
        dispcnt     = 16'h0080;
        rst_n       = 1'b0;
        #1;
        check("rst_vcount", 16'(vcount), 16'd0);
        check("rst_dispstat", dispstat, 16'd0);
        check("rst_irq", 16'({irq_vblank, irq_hblank, irq_vcount}), 16'd0);
        check("rst_pix", 16'({pix_valid, pix_strobe}), 16'd0);
        repeat (n) @(posedge clk_mem);
        @(negedge clk_mem);
        rst_n = 1'b1;
        model_clear();
    endtask

    // one clk_mem cycle: advance model, drive this cycle's inputs, compare
    task automatic run_cycle(input bit wr, input logic [15:0] wd,
                             input logic [1:0] be, input logic [15:0] dc);
        int  dv, dot, line;
        bit  o_vb, o_hb, o_vc, tick_in, line_ev, vis, e_valid;
        bit  e_hbi, e_vbi, e_vci, hb, vb;
        logic [7:0] o_lyc;
        logic [15:0] e_ds;
        @(posedge clk_mem); #1;
        t++;
        dv   = t % C;
        dot  = (t / C) % HT;
        line = (t / (C * HT)) % VT;
        o_vb = m_en_vb; o_hb = m_en_hb; o_vc = m_en_vc; o_lyc = m_lyc;
        if (p_wr) begin
            if (p_be[0]) begin
                m_en_vb = p_wd[3]; m_en_hb = p_wd[4]; m_en_vc = p_wd[5];
            end
            if (p_be[1]) m_lyc = p_wd[15:8];
        end
        tick_in = (dv == 0);
        line_ev = tick_in && dot == 0;
        e_hbi   = tick_in && dot == HV && o_hb;
        e_vbi   = line_ev && line == VV && o_vb;
        e_vci   = line_ev && 8'(line) == o_lyc && o_vc;
        if ((p_wr && p_be[1]) || line_ev) m_vcm = (8'(line) == m_lyc);

        dispstat_wr    = wr;
        dispstat_wdata = wd;
        dispstat_be    = be;
        dispcnt        = dc;
        p_wr = wr; p_wd = wd; p_be = be;
        #1;

        hb      = dot >= HV;
        vb      = line >= VV && line != VT - 1;
        vis     = dot < HV && line < VV;
        e_valid = !dc[7] && vis;
        e_ds    = {m_lyc, 2'b00, m_en_vc, m_en_hb, m_en_vb, m_vcm, hb, vb};
        check("vcount", 16'(vcount), 16'(line));
        check("dispstat", dispstat, e_ds);
        check("irq_hblank", 16'(irq_hblank), 16'(e_hbi));
        check("irq_vblank", 16'(irq_vblank), 16'(e_vbi));
        check("irq_vcount", 16'(irq_vcount), 16'(e_vci));
        check("pix_x", 16'(pix_x), vis ? 16'(dot) : 16'd0);
        check("pix_y", 16'(pix_y), vis ? 16'(line) : 16'd0);
        check("pix_valid", 16'(pix_valid), 16'(e_valid));
        check("pix_strobe", 16'(pix_strobe), 16'(e_valid && dv == 0));
        if (pix_strobe) strobe_cnt++;
    endtask

    task automatic random_run(input int n);
        logic [15:0] dc;
        logic [31:0] r;
        logic [7:0]  ly;
        dc = 16'h0000;
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            if ($urandom_range(0, 99) == 0) dc[7] = ~dc[7];
            dc = {r[31:24], dc[7], r[22:16]};
            ly = ($urandom_range(0, 7) == 0) ? r[15:8] : 8'($urandom_range(0, VT - 1));
            if ($urandom_range(0, 29) == 0)
                run_cycle(1'b1, {ly, r[7:0]}, 2'($urandom_range(0, 3)), dc);
            else
                run_cycle(1'b0, 16'h0000, 2'b00, dc);
        end
    endtask

    initial begin
        model_clear();
        strobe_cnt = 0;
        do_reset(5);

        // write masking during line 0
        run_cycle(1'b1, 16'hFFFF, 2'b11, 16'h0000);
        run_cycle(1'b0, 16'h0000, 2'b00, 16'h0000);
        run_cycle(1'b0, 16'h0000, 2'b00, 16'h0000);
        check("mask_dispstat", dispstat, 16'hFF38);

        // enables on, lyc = 3 (lyc via high byte, enables via low byte)
        run_cycle(1'b1, 16'h0300, 2'b10, 16'h0000);
        run_cycle(1'b1, 16'h0038, 2'b01, 16'h0000);
        random_run(4 * FRAME);

        // mid-frame reset then more random traffic
        do_reset(3);
        run_cycle(1'b1, 16'h0238, 2'b11, 16'h0000);
        random_run(2 * FRAME);

        // full frame unblanked: every visible dot strobed once
        run_cycle(1'b1, 16'h0438, 2'b11, 16'h0000);
        strobe_cnt = 0;
        repeat (FRAME) run_cycle(1'b0, 16'h0000, 2'b00, 16'h0000);
        check("strobes_frame", 16'(strobe_cnt), 16'(HV * VV));

        // full frame in forced blank: no strobes, timing/IRQs still checked
        strobe_cnt = 0;
        repeat (FRAME) run_cycle(1'b0, 16'h0000, 2'b00, 16'h0080);
        check("strobes_blank", 16'(strobe_cnt), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gba_lcd_timing.md
Name: gba_lcd_timing

Overview:
- Display timing generator; sits directly downstream of the I/O register block and consumes its `dispcnt` output.
- Produces GBA-style dot/line counters, the VCOUNT value, DISPSTAT status/control, and single-cycle LCD interrupt requests.
- Drives pixel coordinates and a valid strobe to the renderer.
- The I/O register block muxes `vcount`/`dispstat` into its readback at 0x004/0x006 and forwards DISPSTAT writes here.

Parameters:
- CLK_PER_DOT, 12, clk_mem cycles per LCD dot (50 MHz / 12 ≈ 4.17 MHz, close to 16.78 MHz / 4).
- H_VISIBLE, 240, visible dots per line.
- H_TOTAL, 308, total dots per line.
- V_VISIBLE, 160, visible lines per frame.
- V_TOTAL, 228, total lines per frame.

Ports:
- clk_mem  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dispcnt  in  16  DISPCNT from the I/O register block; only bit 7 (forced blank) is used.
- dispstat_wr  in  1  one-cycle write strobe for DISPSTAT.
- dispstat_wdata  in  16  write data, already aligned to DISPSTAT bit positions.
- dispstat_be  in  2  byte enables; [0] = bits 7:0, [1] = bits 15:8.
- dispstat  out  16  {lyc[7:0], 2'b0, en_vc, en_hb, en_vb, vc_match, hblank, vblank}.
- vcount  out  8  current line, 0..V_TOTAL-1.
- irq_vblank  out  1  one-cycle interrupt request pulse.
- irq_hblank  out  1  one-cycle interrupt request pulse.
- irq_vcount  out  1  one-cycle interrupt request pulse.
- pix_x  out  8  current dot while visible, else 0.
- pix_y  out  8  current line while visible, else 0.
- pix_valid  out  1  high for the whole of every visible dot when not in forced blank.
- pix_strobe  out  1  high on the first clk_mem cycle of each valid dot.

Behaviour:
- Reset (async assert, sync release): div, hcount, vcount, lyc, en_vb, en_hb, en_vc = 0; all outputs 0.
  - After release, the first dot starts at hcount 0, vcount 0.
- Dot divider:
  - div counts 0..CLK_PER_DOT-1, then wraps.
  - dot_tick = (div == CLK_PER_DOT-1).
- Horizontal counter:
  - hcount advances on dot_tick.
  - At H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps V_TOTAL-1 -> 0.
  - All counters are registered; no combinational paths from inputs to counters.
- Status flags, derived from registered counters:
  - hblank = (hcount >= H_VISIBLE).
  - vblank = (vcount >= V_VISIBLE) && (vcount != V_TOTAL-1); line 227 reads vblank = 0.
  - vc_match = (vcount == lyc).
- Interrupts: each pulse lasts exactly one clk_mem cycle, in the cycle after the counter update.
  - irq_hblank: hcount changes H_VISIBLE-1 -> H_VISIBLE, and en_hb = 1. Fires on every line, including vblank lines.
  - irq_vblank: vcount changes V_VISIBLE-1 -> V_VISIBLE, and en_vb = 1.
  - irq_vcount: vcount changes to a value equal to lyc, and en_vc = 1.
  - Writing lyc equal to the current vcount sets vc_match but does NOT pulse irq_vcount.
  - Simultaneous DISPSTAT write and event: the enable values held before the write gate the event.
- DISPSTAT write:
  - be[0] updates en_vb, en_hb, en_vc from wdata[3], [4], [5].
  - be[1] updates lyc from wdata[15:8].
  - Bits 0-2 and 6-7 are read-only and ignore write data.
  - Takes effect on the next cycle.
- Forced blank (dispcnt[7] = 1):
  - pix_valid = 0 and pix_strobe = 0.
  - Counters, flags and IRQs keep running unchanged.
- Pixel outputs:
  - pix_valid = !dispcnt[7] && hcount < H_VISIBLE && vcount < V_VISIBLE.
  - pix_strobe = pix_valid && div == 0.
- Reset mid-frame: counters return to 0 immediately; no IRQ pulse is generated on release.
- Widths: hcount 9 bits, vcount 8 bits, div sized by $clog2(CLK_PER_DOT).
  - Comparisons are unsigned; no counter ever exceeds its total.

Decomposition:
- Package gba_lcd_pkg holds:
  - DISPSTAT bit-index constants (VBLANK=0, HBLANK=1, VCMATCH=2, EN_VB=3, EN_HB=4, EN_VC=5, LYC_LSB=8).
  - The default geometry constants.
  - The IO offsets 12'h004 and 12'h006.
- One natural sub-module, lcd_dot_divider: the div counter and dot_tick. Everything else lives in one module.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles, release -> vcount = 0, dispstat = 0, no IRQ for the first 2880 cycles.
- Line timing: en_hb = 1 -> hblank rises and irq_hblank pulses at cycle 2880 (240*12); line period 3696 cycles; vcount = 1 at cycle 3696.
- VBlank: en_vb = 1 -> irq_vblank pulses once at cycle 591360 (160*3696); vblank = 1 on lines 160..226; vblank = 0 on line 227; frame wraps to vcount 0 at cycle 842688.
- VCount match: write lyc = 5 (be = 2'b10) plus en_vc (be = 2'b01) -> vc_match and irq_vcount at cycle 18480; then write lyc = current vcount -> vc_match = 1, no pulse.
- Write masking: write 16'hFFFF with be = 2'b11 during line 0 -> dispstat = 16'hFF38; bits 0-2 unaffected by the write.
- Forced blank: dispcnt = 16'h0080 -> pix_valid and pix_strobe stay 0 for a full frame while vcount and IRQs are unchanged; clear it -> 240 strobes per visible line.
